// File: rtl/alu_issue_pkg.sv
// Shared ALU select codes, alu_op encodings and issue FSM state for alu_issue_ctrl.
package alu_issue_pkg;

  localparam logic [3:0] ALU_SEL_ADD = 4'b0010;
  localparam logic [3:0] ALU_SEL_SUB = 4'b0110;
  localparam logic [3:0] ALU_SEL_AND = 4'b0000;
  localparam logic [3:0] ALU_SEL_OR  = 4'b0001;
  localparam logic [3:0] ALU_SEL_ILL = 4'b1111;

  localparam logic [1:0] ALU_OP_MEM = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational translation of alu_op/funct3/funct7[5] into the ALU select code.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] sel,
  output logic       illegal
);

  always_comb begin
    sel     = ALU_SEL_ILL;
    illegal = 1'b1;
    unique case (alu_op)
      ALU_OP_MEM: begin sel = ALU_SEL_ADD; illegal = 1'b0; end
      ALU_OP_BR:  begin sel = ALU_SEL_SUB; illegal = 1'b0; end
      ALU_OP_R, ALU_OP_I: begin
        case (funct3)
          3'b000: begin
            // Immediates have no sub form, so bit 30 only matters for R-type.
            sel     = (alu_op == ALU_OP_R && funct7_5) ? ALU_SEL_SUB : ALU_SEL_ADD;
            illegal = 1'b0;
          end
          3'b111: begin sel = ALU_SEL_AND; illegal = 1'b0; end
          3'b110: begin sel = ALU_SEL_OR;  illegal = 1'b0; end
          default: begin sel = ALU_SEL_ILL; illegal = 1'b1; end
        endcase
      end
      default: begin sel = ALU_SEL_ILL; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decode -> registered ALU operands -> captured response (IDLE/EXEC/RESP).
// Define ALU_ISSUE_PERF_EN to add the perf_ops/perf_illegal counters.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_alu_op,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7_5,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [3:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_illegal
`endif
);

  state_t     state;
  logic       ill_q;
  logic [3:0] dec_sel;
  logic       dec_ill;
  logic       accept;

  alu_issue_decode u_dec (
    .alu_op   (req_alu_op),
    .funct3   (req_funct3),
    .funct7_5 (req_funct7_5),
    .sel      (dec_sel),
    .illegal  (dec_ill)
  );

  assign accept = (state == IDLE) && req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      alu_sel     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      ill_q       <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_sel   <= dec_sel;
          alu_a     <= req_a;
          alu_b     <= req_b;
          ill_q     <= dec_ill;
          req_ready <= 1'b0;
          state     <= EXEC;
        end
        EXEC: begin
          // Illegal ops never expose whatever the ALU does with the 1111 select.
          rsp_result  <= ill_q ? '0 : alu_c;
          rsp_zero    <= !ill_q && alu_z;
          rsp_illegal <= ill_q;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops     <= '0;
      perf_illegal <= '0;
    end else if (accept) begin
      perf_ops     <= perf_ops + 32'd1;
      perf_illegal <= perf_illegal + {31'd0, dec_ill};
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU on the sel/a/b -> c/z side.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_alu_op = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_funct7_5 = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        alu_z;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops, perf_illegal;
  int unsigned exp_ops = 0, exp_ill = 0;
`endif

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_a(req_a), .req_b(req_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
`ifdef ALU_ISSUE_PERF_EN
    , .perf_ops(perf_ops), .perf_illegal(perf_illegal)
`endif
  );

  // Garbage on an unknown select so the controller's masking is visible.
  always_comb begin
    alu_c = 32'hDEAD_BEEF;
    alu_z = 1'b1;
    case (alu_sel)
      4'b0010: begin alu_c = alu_a + alu_b; alu_z = (alu_c == 32'd0); end
      4'b0110: begin alu_c = alu_a - alu_b; alu_z = (alu_c == 32'd0); end
      4'b0000: begin alu_c = alu_a & alu_b; alu_z = (alu_c == 32'd0); end
      4'b0001: begin alu_c = alu_a | alu_b; alu_z = (alu_c == 32'd0); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference decode: returns {illegal, sel}.
  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'b00) return {1'b0, 4'b0010};
    if (op == 2'b01) return {1'b0, 4'b0110};
    if (f3 == 3'b111) return {1'b0, 4'b0000};
    if (f3 == 3'b110) return {1'b0, 4'b0001};
    if (f3 == 3'b000) return (op == 2'b10 && f7) ? {1'b0, 4'b0110} : {1'b0, 4'b0010};
    return {1'b1, 4'b1111};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    case (sel)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [4:0]  d;
    rsp_t        e, got;
    logic [31:0] held;
    int          n;
    d = ref_dec(op, f3, f7);
    e.illegal = d[4];
    e.result  = d[4] ? 32'd0 : ref_alu(d[3:0], a, b);
    e.zero    = !d[4] && (e.result == 32'd0);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_alu_op = op; req_funct3 = f3; req_funct7_5 = f7;
    req_a = a; req_b = b;
    sb.push_back(e);
`ifdef ALU_ISSUE_PERF_EN
    exp_ops++;
    if (d[4]) exp_ill++;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("alu_sel", {28'd0, alu_sel}, {28'd0, d[3:0]});
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf_ops", perf_ops, exp_ops);
    chk("perf_illegal", perf_illegal, exp_ill);
`endif
    n = 1;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", n, 2);
    held = rsp_result;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_result", rsp_result, held);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    got.result = rsp_result; got.zero = rsp_zero; got.illegal = rsp_illegal;
    e = sb.pop_front();
    chk("rsp_result", got.result, e.result);
    chk("rsp_zero", {31'd0, got.zero}, {31'd0, e.zero});
    chk("rsp_illegal", {31'd0, got.illegal}, {31'd0, e.illegal});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_outs", {req_ready, rsp_valid, alu_sel, rsp_zero, rsp_illegal},
          {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
      chk("rst_data", alu_a | alu_b | rsp_result, 32'd0);
    end

    issue(2'b10, 3'b000, 1'b1, 32'd5, 32'd5, 0);               // R sub -> zero
    issue(2'b11, 3'b110, 1'b0, 32'hF0, 32'h0F, 4);             // I or with back-pressure
    issue(2'b10, 3'b001, 1'b0, 32'd7, 32'd9, 0);               // sll -> illegal
    issue(2'b00, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);       // load add wraps
    issue(2'b01, 3'b101, 1'b1, 32'd3, 32'd10, 1);              // branch sub wraps negative
    issue(2'b10, 3'b111, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    issue(2'b10, 3'b000, 1'b0, 32'h1234_5678, 32'h1111_1111, 0);
    issue(2'b11, 3'b000, 1'b1, 32'd100, 32'd23, 0);            // I add ignores bit 30
    issue(2'b11, 3'b101, 1'b0, 32'd1, 32'd2, 2);               // I srli -> illegal

    // Reset during EXEC drops the op.
    @(negedge clk);
    req_valid = 1'b1; req_alu_op = 2'b00; req_funct3 = 3'b000;
    req_a = 32'd4; req_b = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {req_ready, rsp_valid, alu_sel}, {1'b1, 1'b0, 4'd0});
    chk("rst_async_a", alu_a, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    exp_ops = 0; exp_ill = 0;
    chk("rst_perf", perf_ops | perf_illegal, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    issue(2'b00, 3'b000, 1'b0, 32'd4, 32'd4, 0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
